vx_pipe_arbiter: RTL
====================

# VX_pipe_arbiter

Shares one fixed-latency, enable-gated datapath pipeline (a shift-register-style unit of DEPTH register stages) among NUM_REQS requesters. The block performs round-robin arbitration and drives the pipeline's enable and data input. It tracks each in-flight operation's valid bit and requester tag in its own resettable shift register, and returns results on a single valid/ready response port. It sits between issue-side requesters and a shared execution or memory-side unit whose data path has no reset.

## Interface
- NUM_REQS, 4: number of requesters, ≥1.
- DATAW, 32: request/response payload width.
- DEPTH, 3: register stages in the shared pipeline, ≥1.
- TAGW, $clog2(NUM_REQS) (min 1): requester tag width.
- CNTW, $clog2(DEPTH+1): width of pending_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS*DATAW  per-requester payload; requester i in bits [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-requester accept; at most one bit high.
- pipe_enable  out  1  advance enable for the external pipeline's stages.
- pipe_data_in  out  DATAW  payload of granted requester, 0 when no grant.
- pipe_data_out  in  DATAW  external pipeline final-stage output.
- rsp_valid  out  1  response valid.
- rsp_data  out  DATAW  equals pipe_data_out.
- rsp_tag  out  TAGW  index of the requester that issued the response.
- rsp_ready  in  1  downstream accept.
- pending_count  out  CNTW  number of valid in-flight stages.
- idle  out  1  high when pending_count==0 and req_valid==0.

## Operation
- stall = rsp_valid & ~rsp_ready. pipe_enable = ~stall & ~reset.
- Arbitration is round-robin. Pointer rr_last is reset to NUM_REQS-1, so requester 0 has first priority. The search starts at rr_last+1 and wraps modulo NUM_REQS. The winner is the first index with req_valid set.
- req_ready[i] = pipe_enable & (winner==i) & req_valid[i]. A handshake fires on req_valid[i] & req_ready[i]. On a fire, rr_last <= i. Otherwise rr_last holds.
- Stage-0 insert: valid_in = any fire, tag_in = winner index. pipe_data_in = req_data of winner on fire, else 0.
- Internal valid/tag shift register has DEPTH stages and advances only when pipe_enable=1. Valid bits reset to 0. Tag bits are not reset. With DEPTH=1 it is a single register.
- rsp_valid = valid[DEPTH-1]. rsp_tag = tag[DEPTH-1].
- Bubbles are not collapsed: during a stall the whole pipeline freezes, including empty stages.
- pending_count = popcount of valid[DEPTH-1:0], range 0..DEPTH.
- Response retires on rsp_valid & rsp_ready. That same cycle the pipeline advances, so a new fire is permitted.
- req_valid may drop without a fire (no hold obligation on requesters). The arbiter re-evaluates every cycle.

## Timing
- Request latency: a fire in cycle t produces rsp_valid in cycle t+DEPTH, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput is one request per cycle when rsp_ready is held high.
- req_ready is combinational from req_valid, rsp_ready and state. It has no combinational path from req_data.
- During reset cycles and the first edge: valid all 0, rr_last=NUM_REQS-1, rsp_valid=0, pending_count=0, req_ready=0, pipe_enable=0, pipe_data_in=0, idle=~|req_valid.
- Reset mid-operation: all in-flight operations are dropped with no response. The external data path is not cleared; its stale contents are masked by the valid bits.
- A simultaneous stall and new req_valid produces no fire; the pointer is unchanged.
- Wrap-around: after a grant to NUM_REQS-1, the search starts at 0.

## Test plan
- Single requester, NUM_REQS=4, DEPTH=3, rsp_ready=1: req_valid=0001 with data 0xA5 for 1 cycle at t. Required: rsp_valid=1, rsp_data=0xA5, rsp_tag=0 exactly at t+3 for 1 cycle; pending_count goes 1,1,1,0.
- Full contention: req_valid=1111 held 8 cycles, rsp_ready=1. Required: grants 0,1,2,3,0,1,2,3, one per cycle; rsp_tag sequence identical, starting at t+3; no bubbles.
- Backpressure: stream requests, drop rsp_ready for 2 cycles while rsp_valid=1. Required: rsp_data/rsp_tag stable, pipe_enable=0, req_ready=0 during the stall; order preserved; latency +2.
- Reset mid-flight: 3 ops in flight, assert reset 1 cycle. Required: rsp_valid=0, pending_count=0, next grant goes to requester 0 first; no stale responses emerge afterwards.
- DEPTH=1, NUM_REQS=1: back-to-back requests with alternating rsp_ready. Required: responses 1 cycle after each fire; no loss or duplication; TAGW=1, rsp_tag=0.
- Idle: no requests after drain. Required: idle=1 exactly when pending_count==0 and req_valid==0; idle=0 in the same cycle any req_valid rises.

Source files
------------

// File: rtl/vx_pipe_arbiter_if.sv
// Request/response handshake bundle for vx_pipe_arbiter.
// master drives requests and accepts responses; slave is the arbiter.
interface vx_pipe_arbiter_if #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 32,
    parameter int unsigned TAGW     = 2
);
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      rsp_valid;
    logic [DATAW-1:0]          rsp_data;
    logic [TAGW-1:0]           rsp_tag;
    logic                      rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/vx_pipe_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency pipeline; tracks in-flight
// valid/tag alongside the external datapath and returns results on one port.
module vx_pipe_arbiter #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int unsigned CNTW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_pipe_arbiter_if.slave     bus,
    output logic                 pipe_enable,
    output logic [DATAW-1:0]     pipe_data_in,
    input  logic [DATAW-1:0]     pipe_data_out,
    output logic [CNTW-1:0]      pending_count,
    output logic                 idle
);

    logic [TAGW-1:0]     rr_last_q;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [TAGW-1:0]     tag_q [DEPTH];
    logic [TAGW-1:0]     tag_d [DEPTH];

    logic                stall;
    logic                fire;
    logic [TAGW-1:0]     winner;
    logic                hi_found;
    logic [TAGW-1:0]     hi_idx;
    logic [TAGW-1:0]     lo_idx;
    logic [NUM_REQS-1:0] req_ready;

    assign bus.rsp_valid = valid_q[DEPTH-1];
    assign bus.rsp_tag   = tag_q[DEPTH-1];
    assign bus.rsp_data  = pipe_data_out;
    assign bus.req_ready = req_ready;

    assign stall       = valid_q[DEPTH-1] & ~bus.rsp_ready;
    assign pipe_enable = ~stall & ~reset;

    // Smallest requesting index above rr_last wins; otherwise wrap to the
    // smallest requesting index at or below it. Descending scan keeps the lowest.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (TAGW'(i) > rr_last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = TAGW'(i);
                end else begin
                    lo_idx   = TAGW'(i);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        req_ready    = '0;
        pipe_data_in = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = pipe_enable & bus.req_valid[i] & (winner == TAGW'(i));
            if (req_ready[i]) begin
                pipe_data_in = bus.req_data[i*DATAW +: DATAW];
            end
        end
    end

    assign fire = |req_ready;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = fire;
        tag_d[0]   = winner;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            rr_last_q <= TAGW'(NUM_REQS - 1);
        end else begin
            if (pipe_enable) begin
                valid_q <= valid_d;
            end
            if (fire) begin
                rr_last_q <= winner;
            end
        end
    end

    // Tags need no reset: they are only observed through valid bits.
    always_ff @(posedge clk) begin
        if (pipe_enable) begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_count = pending_count + CNTW'(valid_q[i]);
        end
    end

    assign idle = (pending_count == '0) & ~(|bus.req_valid);

    assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (reset) pending_count <= CNTW'(DEPTH));

endmodule
